data_mem_bus: RTL and testbench

Memory-side stage that sits directly downstream of the single-cycle ARM core. It consumes the core's data address, store data and write strobe, and returns load data. It decodes each access into a word-addressed data RAM or a small memory-mapped I/O block: a GPIO output register, a synchronized GPIO input, and a programmable down-counting timer. Reads are combinational so a load completes in the core's single cycle; all state updates on the clock edge.

---
 rtl/data_mem_bus.sv | 120 ++++++++++++
 tb/tb_data_mem_bus.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bus.sv
// Memory-side stage for the single-cycle core: word-addressed data RAM plus a
// small I/O block (GPIO out, synchronized GPIO in, down-counting timer).
module data_mem_bus #(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] IO_BASE   = 32'h0000_0400,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_expired
);

  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
  localparam logic [31:0] A_GPIO_OUT = IO_BASE + 32'h00;
  localparam logic [31:0] A_GPIO_IN  = IO_BASE + 32'h04;
  localparam logic [31:0] A_T_LOAD   = IO_BASE + 32'h08;
  localparam logic [31:0] A_T_CTRL   = IO_BASE + 32'h0C;
  localparam logic [31:0] A_T_COUNT  = IO_BASE + 32'h10;

  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       waddr;
  logic [AW-1:0]     ram_idx;
  logic              ram_sel;
  logic              unused_addr_lsb;

  logic [GPIO_W-1:0] gpio_sync1, gpio_sync2;
  logic [31:0]       t_load, t_count;
  logic              t_en, t_auto, t_expired;

  logic              we_ram, we_gpio, we_load, we_ctrl;
  logic              t_fire;

  assign waddr           = {Addr[31:2], 2'b00};
  assign ram_idx         = Addr[AW+1:2];
  assign ram_sel         = (waddr < RAM_BYTES);
  assign unused_addr_lsb = ^Addr[1:0];

  assign we_ram  = MemWrite && ram_sel;
  assign we_gpio = MemWrite && (waddr == A_GPIO_OUT);
  assign we_load = MemWrite && (waddr == A_T_LOAD);
  assign we_ctrl = MemWrite && (waddr == A_T_CTRL);

  // Expiry is judged on the pre-edge enable and count.
  assign t_fire = t_en && (t_count == 32'd1);

  assign timer_expired = t_expired;

  // RAM is never reset; a store coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (we_ram && !reset)
      ram[ram_idx] <= WriteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
      t_load     <= '0;
      t_count    <= '0;
      t_en       <= 1'b0;
      t_auto     <= 1'b0;
      t_expired  <= 1'b0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;

      if (we_gpio)
        gpio_out <= WriteData[GPIO_W-1:0];

      if (t_en) begin
        if (t_count > 32'd1)
          t_count <= t_count - 32'd1;
        else if (t_fire)
          t_count <= t_auto ? t_load : 32'd0;
      end

      // A LOAD write overrides any decrement or reload on the same edge.
      if (we_load) begin
        t_load  <= WriteData;
        t_count <= WriteData;
      end

      if (we_ctrl) begin
        t_en   <= WriteData[0];
        t_auto <= WriteData[1];
        if (WriteData[2])
          t_expired <= 1'b0;
      end

      // Set beats write-1-to-clear when both land on one edge.
      if (t_fire)
        t_expired <= 1'b1;
    end
  end

  always_comb begin
    ReadData = 32'h0;
    if (ram_sel) begin
      ReadData = ram[ram_idx];
    end else begin
      case (waddr)
        A_GPIO_OUT: ReadData = 32'(gpio_out);
        A_GPIO_IN:  ReadData = 32'(gpio_sync2);
        A_T_LOAD:   ReadData = t_load;
        A_T_CTRL:   ReadData = {29'h0, t_expired, t_auto, t_en};
        A_T_COUNT:  ReadData = t_count;
        default:    ReadData = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bus.sv
// Bench for data_mem_bus: table of access vectors plus hand-built timer,
// GPIO-synchronizer and async-reset sequences, checked through a scoreboard.
module tb_data_mem_bus;

  localparam logic [31:0] IO = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_expired;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  data_mem_bus #(.RAM_WORDS(64), .IO_BASE(IO), .GPIO_W(8)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .timer_expired(timer_expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Read data is combinational, so it is sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      check(e.name, ReadData, e.exp);
    end
  end

  // One bus cycle: drive after a rising edge, expectation queued, edge taken.
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic chk, input logic [31:0] e, input string nm);
    MemWrite  = we;
    Addr      = a;
    WriteData = wd;
    if (chk) sb.push_back('{nm, e});
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    cycle(1'b0, a, 32'h0, 1'b1, e, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    cycle(1'b1, a, wd, 1'b0, 32'h0, "");
  endtask

  task automatic add(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic chk, input logic [31:0] e, input string nm);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.chk = chk; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; Addr = '0; WriteData = '0; gpio_in = '0;

    add(1, 32'h008, 32'hDEADBEEF, 0, 0, "");
    add(1, 32'h00C, 32'h12345678, 0, 0, "");
    add(0, 32'h008, 0, 1, 32'hDEADBEEF, "ram_rd_08");
    add(0, 32'h00B, 0, 1, 32'hDEADBEEF, "ram_rd_0b");
    add(0, 32'h00C, 0, 1, 32'h12345678, "ram_rd_0c");
    add(1, 32'h000, 32'hA1A1A1A1, 0, 0, "");
    add(1, 32'h0FC, 32'hCAFEF00D, 0, 0, "");
    add(0, 32'h0FF, 0, 1, 32'hCAFEF00D, "ram_last_word");
    add(1, 32'h100, 32'hFFFFFFFF, 0, 0, "");
    add(1, 32'h200, 32'hFFFFFFFF, 0, 0, "");
    add(1, 32'h414, 32'hFFFFFFFF, 0, 0, "");
    add(0, 32'h100, 0, 1, 32'h0, "hole_ram_end");
    add(0, 32'h000, 0, 1, 32'hA1A1A1A1, "ram_no_wrap");
    add(0, 32'h200, 0, 1, 32'h0, "hole_200");
    add(0, 32'h414, 0, 1, 32'h0, "hole_414");
    add(1, IO + 4,  32'hFFFFFFFF, 0, 0, "");
    add(0, IO + 4,  0, 1, 32'h0, "gpio_in_ro");
    add(1, IO + 0,  32'hFFFFFFA5, 0, 0, "");
    add(0, IO + 0,  0, 1, 32'h000000A5, "gpio_out_rd");
    add(1, 32'h008, 32'h11111111, 1, 32'hDEADBEEF, "ram_same_cycle_old");
    add(0, 32'h008, 0, 1, 32'h11111111, "ram_store_visible");

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_timer_expired", 32'(timer_expired), 32'h0);
    reset = 1'b0;
    rd(IO + 32'h00, 32'h0, "rst_gpio_out_rd");
    rd(IO + 32'h04, 32'h0, "rst_gpio_in_rd");
    rd(IO + 32'h08, 32'h0, "rst_load");
    rd(IO + 32'h0C, 32'h0, "rst_ctrl");
    rd(IO + 32'h10, 32'h0, "rst_count");

    foreach (vecs[i])
      cycle(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].chk, vecs[i].exp, vecs[i].name);
    check("gpio_out_port", 32'(gpio_out), 32'hA5);

    // GPIO input synchronizer: two edges of latency
    gpio_in = 8'h3C;
    cycle(0, IO + 4, 0, 0, 0, "");
    rd(IO + 4, 32'h0, "gpio_sync_1edge");
    rd(IO + 4, 32'h3C, "gpio_sync_2edge");

    // Timer one-shot
    wr(IO + 8, 32'd3);
    wr(IO + 32'hC, 32'h1);
    rd(IO + 32'h10, 32'd3, "os_cnt3");
    rd(IO + 32'h10, 32'd2, "os_cnt2");
    check("os_not_expired", 32'(timer_expired), 32'h0);
    rd(IO + 32'h10, 32'd1, "os_cnt1");
    check("os_expired_port", 32'(timer_expired), 32'h1);
    rd(IO + 32'h10, 32'd0, "os_cnt0");
    rd(IO + 32'h10, 32'd0, "os_cnt_hold");
    rd(IO + 32'hC, 32'h5, "os_ctrl_expired");
    wr(IO + 32'hC, 32'h5);
    rd(IO + 32'hC, 32'h1, "os_clear_keeps_en");
    check("os_cleared_port", 32'(timer_expired), 32'h0);
    wr(IO + 8, 32'd0);
    for (int i = 0; i < 4; i++) rd(IO + 32'hC, 32'h1, "zero_load_noexp");
    rd(IO + 32'h10, 32'd0, "zero_load_cnt");

    // Timer autoreload and same-edge races
    wr(IO + 32'hC, 32'h0);
    wr(IO + 8, 32'd4);
    wr(IO + 32'hC, 32'h3);
    rd(IO + 32'h10, 32'd4, "ar_cnt4");
    rd(IO + 32'h10, 32'd3, "ar_cnt3");
    rd(IO + 32'h10, 32'd2, "ar_cnt2");
    check("ar_not_yet", 32'(timer_expired), 32'h0);
    rd(IO + 32'h10, 32'd1, "ar_cnt1");
    check("ar_expired_port", 32'(timer_expired), 32'h1);
    rd(IO + 32'h10, 32'd4, "ar_reload");
    cycle(1, IO + 32'hC, 32'h7, 1, 32'h7, "ar_ctrl_before_clear");
    check("ar_cleared", 32'(timer_expired), 32'h0);
    rd(IO + 32'h10, 32'd2, "ar_cnt2_b");
    cycle(1, IO + 32'hC, 32'h7, 1, 32'h3, "ar_ctrl_at_expiry");
    rd(IO + 32'hC, 32'h7, "race_set_wins");
    check("race_set_wins_port", 32'(timer_expired), 32'h1);
    rd(IO + 32'h10, 32'd3, "ar_period_cnt3");
    cycle(1, IO + 8, 32'd10, 1, 32'd4, "ld_race_old_load");
    rd(IO + 32'h10, 32'd10, "load_priority");
    rd(IO + 32'h10, 32'd9, "load_then_dec");
    wr(IO + 0, 32'h000000A5);
    check("pre_rst_gpio", 32'(gpio_out), 32'hA5);
    check("pre_rst_expired", 32'(timer_expired), 32'h1);

    // Asynchronous reset mid-cycle
    Addr = IO + 32'h10;
    #1;
    check("pre_rst_count", ReadData, 32'd7);
    #1;
    reset = 1'b1;
    #1;
    check("async_gpio_out", 32'(gpio_out), 32'h0);
    check("async_expired", 32'(timer_expired), 32'h0);
    check("async_count", ReadData, 32'h0);
    Addr = IO + 32'hC;
    #1;
    check("async_ctrl", ReadData, 32'h0);
    MemWrite = 1'b1; Addr = 32'h00C; WriteData = 32'h0;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    reset = 1'b0;
    rd(32'h00C, 32'h12345678, "ram_survives_reset");
    rd(IO + 32'h10, 32'h0, "post_rst_count_hold");
    rd(IO + 32'h00, 32'h0, "post_rst_gpio_rd");

    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
